// File: rtl/mipi_dsi_pkg.sv
// -----------------------------------------------------------------------------
// mipi_dsi_pkg
// Shared DSI definitions for the transmit sync generator and the receive-side
// HSync detector. Both sides compare against the same data type constants.
//   DT_*        : 6-bit DSI data type codes for sync and pixel-stream packets
//   CNT_W       : width of the line / frame position counters
//   WC_W        : width of the long-packet word count field
//   tx_state_e  : sync generator control state
// -----------------------------------------------------------------------------
package mipi_dsi_pkg;

  localparam int DT_W  = 6;
  localparam int CNT_W = 12;
  localparam int WC_W  = 16;

  localparam logic [DT_W-1:0] DT_VSS    = 6'h01;
  localparam logic [DT_W-1:0] DT_VSE    = 6'h11;
  localparam logic [DT_W-1:0] DT_HSS    = 6'h21;
  localparam logic [DT_W-1:0] DT_HSE    = 6'h31;
  localparam logic [DT_W-1:0] DT_RGB888 = 6'h3E;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } tx_state_e;

endpackage

// File: rtl/mipi_tx_timing_cnt.sv
// -----------------------------------------------------------------------------
// mipi_tx_timing_cnt
// Horizontal / vertical position counters for the DSI video timing, plus the
// position flags decoded from them.
//   CLKn, RSTn   : clock and synchronous active-low reset
//   clr          : hold both counters at 0
//   adv          : advance one position (low = frozen)
//   line_start   : h = 0
//   hse_pos      : h = H_SYNC
//   active_start : h = H_SYNC + H_BP
//   active_line  : v inside the active line range
//   pix_window   : h inside the active pixel range
//   frame_first  : v = 0
//   vse_line     : v = V_SYNC
//   frame_last   : last position of the frame
// -----------------------------------------------------------------------------
module mipi_tx_timing_cnt
  import mipi_dsi_pkg::*;
#(
  parameter int H_SYNC   = 4,
  parameter int H_BP     = 88,
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4
) (
  input  logic CLKn,
  input  logic RSTn,
  input  logic clr,
  input  logic adv,
  output logic line_start,
  output logic hse_pos,
  output logic active_start,
  output logic active_line,
  output logic pix_window,
  output logic frame_first,
  output logic vse_line,
  output logic frame_last
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int CW1     = CNT_W + 1;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_HSE   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] H_ACT0  = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] V_VSE   = CNT_W'(V_SYNC);
  // Range ends can reach 4096, so range compares use one extra bit.
  localparam logic [CW1-1:0]   PIX_LO  = CW1'(H_SYNC + H_BP);
  localparam logic [CW1-1:0]   PIX_HI  = CW1'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW1-1:0]   VACT_LO = CW1'(V_SYNC + V_BP);
  localparam logic [CW1-1:0]   VACT_HI = CW1'(V_SYNC + V_BP + V_ACTIVE);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  always_ff @(posedge CLKn) begin
    if (!RSTn || clr) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (adv) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    line_start   = (h_cnt == '0);
    hse_pos      = (h_cnt == H_HSE);
    active_start = (h_cnt == H_ACT0);
    active_line  = ({1'b0, v_cnt} >= VACT_LO) && ({1'b0, v_cnt} < VACT_HI);
    pix_window   = ({1'b0, h_cnt} >= PIX_LO) && ({1'b0, h_cnt} < PIX_HI);
    frame_first  = (v_cnt == '0);
    vse_line     = (v_cnt == V_VSE);
    frame_last   = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  end

endmodule

// File: rtl/mipi_tx_sync_gen.sv
// -----------------------------------------------------------------------------
// mipi_tx_sync_gen
// DSI video-mode timing generator. Walks the line/frame raster and issues one
// packet command per sync event (VSS, VSE, HSS, HSE, RGB888 header) on a
// valid/ready interface toward the TX packetizer. While a command waits for
// acceptance the raster is frozen, so every stall cycle stretches the frame.
//   CLKn, RSTn         : clock and synchronous active-low reset
//   Enable             : run request, sampled in idle and at frame end
//   Tx_cmd_ready       : packetizer accepts the pending command
//   Tx_cmd_valid       : command pending
//   Tx_cmd_data_type   : DSI data type of the pending command
//   Tx_cmd_word_count  : long-packet word count (0 for short packets)
//   Pixel_req          : gates the upstream pixel source
//   Frame_start        : first position of each frame
//   Busy               : generator not idle
// -----------------------------------------------------------------------------
module mipi_tx_sync_gen
  import mipi_dsi_pkg::*;
#(
  parameter int H_SYNC   = 4,
  parameter int H_BP     = 88,
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4
) (
  input  logic            CLKn,
  input  logic            RSTn,
  input  logic            Enable,
  input  logic            Tx_cmd_ready,
  output logic            Tx_cmd_valid,
  output logic [DT_W-1:0] Tx_cmd_data_type,
  output logic [WC_W-1:0] Tx_cmd_word_count,
  output logic            Pixel_req,
  output logic            Frame_start,
  output logic            Busy
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam logic [WC_W-1:0] WC_RGB = WC_W'(H_ACTIVE * 3);

  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_total
    $error("mipi_tx_sync_gen: H_TOTAL / V_TOTAL exceed the 12-bit counter range");
  end
  if (H_ACTIVE * 3 > 65535) begin : g_bad_wc
    $error("mipi_tx_sync_gen: H_ACTIVE*3 does not fit the 16-bit word count");
  end
  // Two-cycle event spacing guarantees a single outstanding command.
  if (H_SYNC < 2 || H_BP < 2 || H_ACTIVE < 2 || H_FP < 2) begin : g_bad_h
    $error("mipi_tx_sync_gen: horizontal segments must be at least 2 cycles");
  end
  if (V_SYNC < 1 || V_BP < 1 || V_ACTIVE < 1 || V_FP < 1) begin : g_bad_v
    $error("mipi_tx_sync_gen: vertical segments must be at least 1 line");
  end

  tx_state_e       state;
  tx_state_e       state_nxt;
  logic            stall;
  logic            accept;
  logic            adv;
  logic            clr;
  logic            line_start;
  logic            hse_pos;
  logic            active_start;
  logic            active_line;
  logic            pix_window;
  logic            frame_first;
  logic            vse_line;
  logic            frame_last;
  logic            ev_hit;
  logic [DT_W-1:0] ev_type;
  logic [WC_W-1:0] ev_wc;
  logic            vld_p1;
  logic [DT_W-1:0] cmd_type_p1;
  logic [WC_W-1:0] cmd_wc_p1;
  logic            pix_req_p1;

  assign stall  = vld_p1 && !Tx_cmd_ready;
  assign accept = vld_p1 && Tx_cmd_ready;

  mipi_tx_timing_cnt #(
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .H_ACTIVE(H_ACTIVE),
    .H_FP    (H_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP),
    .V_ACTIVE(V_ACTIVE),
    .V_FP    (V_FP)
  ) u_cnt (
    .CLKn        (CLKn),
    .RSTn        (RSTn),
    .clr         (clr),
    .adv         (adv),
    .line_start  (line_start),
    .hse_pos     (hse_pos),
    .active_start(active_start),
    .active_line (active_line),
    .pix_window  (pix_window),
    .frame_first (frame_first),
    .vse_line    (vse_line),
    .frame_last  (frame_last)
  );

  always_ff @(posedge CLKn) begin
    if (!RSTn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Enable only matters in idle and on the last position of a frame.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (Enable) state_nxt = ST_RUN;
      ST_RUN: begin
        if (stall) begin
          state_nxt = ST_WAIT;
        end else if (frame_last && !Enable) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (accept) begin
          state_nxt = (frame_last && !Enable) ? ST_IDLE : ST_RUN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    clr         = (state == ST_IDLE);
    adv         = (state != ST_IDLE) && !stall;
    Busy        = (state != ST_IDLE);
    Frame_start = (state == ST_RUN) && line_start && frame_first;
  end

  // Line-start packet type depends on which line of the vertical sync it is.
  always_comb begin
    ev_hit  = 1'b0;
    ev_type = DT_HSS;
    ev_wc   = '0;
    if (line_start) begin
      ev_hit  = 1'b1;
      ev_type = frame_first ? DT_VSS : (vse_line ? DT_VSE : DT_HSS);
    end else if (hse_pos) begin
      ev_hit  = 1'b1;
      ev_type = DT_HSE;
    end else if (active_start && active_line) begin
      ev_hit  = 1'b1;
      ev_type = DT_RGB888;
      ev_wc   = WC_RGB;
    end
  end

  // Stage p1: registered command and pixel gate
  always_ff @(posedge CLKn) begin
    if (!RSTn) begin
      vld_p1      <= 1'b0;
      cmd_type_p1 <= '0;
      cmd_wc_p1   <= '0;
      pix_req_p1  <= 1'b0;
    end else begin
      if (adv && ev_hit) begin
        vld_p1      <= 1'b1;
        cmd_type_p1 <= ev_type;
        cmd_wc_p1   <= ev_wc;
      end else if (accept) begin
        vld_p1 <= 1'b0;
      end
      if (clr) begin
        pix_req_p1 <= 1'b0;
      end else if (adv) begin
        pix_req_p1 <= active_line && pix_window;
      end
    end
  end

  assign Tx_cmd_valid      = vld_p1;
  assign Tx_cmd_data_type  = cmd_type_p1;
  assign Tx_cmd_word_count = cmd_wc_p1;
  assign Pixel_req         = pix_req_p1;

endmodule

// File: tb/tb_mipi_tx_sync_gen.sv
`timescale 1ns/1ps
module tb_mipi_tx_sync_gen;

  localparam int HS = 4, HB = 4, HA = 8, HF = 4;
  localparam int VS = 2, VB = 1, VA = 3, VF = 1;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FRAME = HT * VT;

  localparam logic [5:0] X_VSS = 6'h01;
  localparam logic [5:0] X_VSE = 6'h11;
  localparam logic [5:0] X_HSS = 6'h21;
  localparam logic [5:0] X_HSE = 6'h31;
  localparam logic [5:0] X_RGB = 6'h3E;

  logic        CLKn = 1'b0;
  logic        RSTn = 1'b0;
  logic        Enable = 1'b0;
  logic        Tx_cmd_ready = 1'b1;
  logic        Tx_cmd_valid;
  logic [5:0]  Tx_cmd_data_type;
  logic [15:0] Tx_cmd_word_count;
  logic        Pixel_req;
  logic        Frame_start;
  logic        Busy;

  mipi_tx_sync_gen #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF)
  ) dut (
    .CLKn             (CLKn),
    .RSTn             (RSTn),
    .Enable           (Enable),
    .Tx_cmd_ready     (Tx_cmd_ready),
    .Tx_cmd_valid     (Tx_cmd_valid),
    .Tx_cmd_data_type (Tx_cmd_data_type),
    .Tx_cmd_word_count(Tx_cmd_word_count),
    .Pixel_req        (Pixel_req),
    .Frame_start      (Frame_start),
    .Busy             (Busy)
  );

  always #5 CLKn = ~CLKn;

  typedef struct {
    logic [5:0]  dt;
    logic [15:0] wc;
    int          off;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_bad = 0;

  task automatic chk_eq(input string nm, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference model: frame positions counted in non-stalled cycles from the
  // Frame_start cycle (position 0). A command appears one cycle after its event.
  function automatic bit model_active_line(input int v);
    return (v >= VS + VB) && (v < VS + VB + VA);
  endfunction

  function automatic bit model_pix(input int p);
    int v = p / HT;
    int h = p % HT;
    return model_active_line(v) && (h > HS + HB) && (h <= HS + HB + HA);
  endfunction

  task automatic push_frame();
    exp_t e;
    for (int v = 0; v < VT; v++) begin
      e.wc  = 16'd0;
      e.off = v * HT + 1;
      e.dt  = (v == 0) ? X_VSS : ((v == VS) ? X_VSE : X_HSS);
      exp_q.push_back(e);
      e.off = v * HT + HS + 1;
      e.dt  = X_HSE;
      exp_q.push_back(e);
      if (model_active_line(v)) begin
        e.off = v * HT + HS + HB + 1;
        e.dt  = X_RGB;
        e.wc  = 16'(HA * 3);
        exp_q.push_back(e);
      end
    end
  endtask

  // Monitor / scoreboard
  int          fcyc = 0;
  int          raw = 0;
  int          last_period = 0;
  bit          have_fs = 1'b0;
  bit          pv = 1'b0;
  bit          pr = 1'b1;
  logic [5:0]  pt = '0;
  logic [15:0] pw = '0;
  exp_t        me;

  always @(negedge CLKn) begin
    if (!RSTn) begin
      fcyc    = 0;
      raw     = 0;
      have_fs = 1'b0;
      pv      = 1'b0;
      pr      = 1'b1;
    end else begin
      raw++;
      if (Frame_start) begin
        if (have_fs) begin
          chk_eq("frame_len_unstalled", fcyc, FRAME);
          last_period = raw;
        end
        have_fs = 1'b1;
        fcyc    = 0;
        raw     = 0;
      end
      if (Busy && have_fs) begin
        chk_eq("pixel_req", Pixel_req, model_pix(fcyc));
        if (Tx_cmd_valid && !pv) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_bad++;
            $display("FAIL unexpected_cmd: got type %0h, required no command", Tx_cmd_data_type);
          end else begin
            me = exp_q.pop_front();
            chk_eq("cmd_type", Tx_cmd_data_type, me.dt);
            chk_eq("cmd_wc", Tx_cmd_word_count, me.wc);
            chk_eq("cmd_pos", fcyc, me.off);
          end
        end
      end else if (Busy) begin
        n_chk++;
        n_bad++;
        $display("FAIL frame_start_missing: got busy without frame start, required frame start");
        have_fs = 1'b1;
      end else begin
        chk_eq("idle_valid", Tx_cmd_valid, 0);
        chk_eq("idle_pix", Pixel_req, 0);
        have_fs = 1'b0;
      end
      if (pv && !pr) begin
        chk_eq("hold_valid", Tx_cmd_valid, 1);
        chk_eq("hold_type", Tx_cmd_data_type, pt);
        chk_eq("hold_wc", Tx_cmd_word_count, pw);
      end
      if (!(Tx_cmd_valid && !Tx_cmd_ready)) fcyc++;
      pv = Tx_cmd_valid;
      pr = Tx_cmd_ready;
      pt = Tx_cmd_data_type;
      pw = Tx_cmd_word_count;
    end
  end

  // Stimulus
  task automatic step();
    @(posedge CLKn);
    #2;
  endtask

  task automatic rnd_ready();
    Tx_cmd_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_fs(input int bound, input bit rnd);
    int i;
    for (i = 0; i < bound; i++) begin
      step();
      if (rnd) rnd_ready();
      if (Frame_start) break;
    end
    chk_eq("wait_frame_start_in_time", (i < bound), 1);
  endtask

  task automatic wait_hse(input int bound, input int cnt);
    int i;
    int n = 0;
    for (i = 0; i < bound; i++) begin
      step();
      if (Tx_cmd_valid && Tx_cmd_data_type == X_HSE) n++;
      if (n == cnt) break;
    end
    chk_eq("wait_hse_in_time", (i < bound), 1);
  endtask

  task automatic wait_idle(input int bound, input bit rnd);
    int i;
    for (i = 0; i < bound; i++) begin
      step();
      if (rnd) rnd_ready();
      if (!Busy) break;
    end
    chk_eq("wait_idle_in_time", (i < bound), 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_valid"}, Tx_cmd_valid, 0);
    chk_eq({tag, "_type"}, Tx_cmd_data_type, 0);
    chk_eq({tag, "_wc"}, Tx_cmd_word_count, 0);
    chk_eq({tag, "_pix"}, Pixel_req, 0);
    chk_eq({tag, "_fs"}, Frame_start, 0);
    chk_eq({tag, "_busy"}, Busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTn = 1'b0;
    Enable = 1'b0;
    Tx_cmd_ready = 1'b1;
    repeat (3) step();
    chk_all_zero("reset");
    RSTn = 1'b1;
    step();
    chk_all_zero("idle");

    // Frames 1-4: ready high, backpressure, random ready, Enable dropped.
    repeat (4) push_frame();
    Enable = 1'b1;
    wait_fs(50, 1'b0);
    wait_fs(400, 1'b0);
    step();
    chk_eq("period_ready_high", last_period, FRAME);

    wait_hse(400, 4);
    Tx_cmd_ready = 1'b0;
    repeat (5) step();
    Tx_cmd_ready = 1'b1;
    wait_fs(600, 1'b0);
    step();
    chk_eq("period_backpressure", last_period, FRAME + 5);

    wait_fs(3000, 1'b1);
    repeat (HT + 2) begin
      step();
      rnd_ready();
    end
    Enable = 1'b0;
    wait_idle(3000, 1'b1);
    Tx_cmd_ready = 1'b1;
    chk_eq("queue_drained", exp_q.size(), 0);
    repeat (30) step();
    chk_eq("stays_idle", Busy, 0);

    // Reset while a command is stalled.
    push_frame();
    Enable = 1'b1;
    wait_fs(50, 1'b0);
    wait_hse(50, 1);
    Tx_cmd_ready = 1'b0;
    repeat (2) step();
    RSTn = 1'b0;
    exp_q.delete();
    step();
    RSTn = 1'b1;
    Tx_cmd_ready = 1'b1;
    chk_all_zero("wait_reset");
    push_frame();
    wait_fs(50, 1'b0);
    step();
    chk_eq("vss_after_reset_valid", Tx_cmd_valid, 1);
    chk_eq("vss_after_reset_type", Tx_cmd_data_type, X_VSS);
    repeat (20) step();
    Enable = 1'b0;
    wait_idle(400, 1'b0);
    chk_eq("queue_drained_after_reset", exp_q.size(), 0);
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
